map_mem_arbiter: RTL

Shares the single `map_mem` sprite-pattern lookup (6-bit sprite select, 4-bit x/y, 2-bit pixel) between two requesters. The display requester (port A) fetches one full 16-pixel sprite row per request; the game-logic requester (port B) fetches single pixels, e.g. for collision tests. A fixed-priority scheme with a starvation limit issues one address per cycle to `map_mem`. Returned pixels are tagged back to the owning port through a 2-stage pipeline.

---
 rtl/map_mem_arbiter_if.sv | 45 ++++
 rtl/map_mem_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/map_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// map_mem_arbiter_if
// Bundles the two requester ports and the map_mem lookup bus of the
// sprite-pattern arbiter.
//   Port A (display row fetch):  a_req, a_select[5:0], a_y[3:0] -> a_ack,
//                                a_pix_valid, a_pix_x[3:0], a_pix[1:0], a_done
//   Port B (single pixel fetch): b_req, b_select[5:0], b_x[3:0], b_y[3:0]
//                                -> b_ack, b_valid, b_pix[1:0]
//   map_mem bus:                 mem_select[5:0], mem_x[3:0], mem_y[3:0]
//                                -> mem_out[1:0] (one cycle later)
// Modports: slave = arbiter side, master = requester/memory side.
// ---------------------------------------------------------------------------
interface map_mem_arbiter_if;
  logic       a_req;
  logic [5:0] a_select;
  logic [3:0] a_y;
  logic       a_ack;
  logic       a_pix_valid;
  logic [3:0] a_pix_x;
  logic [1:0] a_pix;
  logic       a_done;
  logic       b_req;
  logic [5:0] b_select;
  logic [3:0] b_x;
  logic [3:0] b_y;
  logic       b_ack;
  logic       b_valid;
  logic [1:0] b_pix;
  logic [5:0] mem_select;
  logic [3:0] mem_x;
  logic [3:0] mem_y;
  logic [1:0] mem_out;

  modport slave (
    input  a_req, a_select, a_y, b_req, b_select, b_x, b_y, mem_out,
    output a_ack, a_pix_valid, a_pix_x, a_pix, a_done,
    output b_ack, b_valid, b_pix, mem_select, mem_x, mem_y
  );

  modport master (
    output a_req, a_select, a_y, b_req, b_select, b_x, b_y, mem_out,
    input  a_ack, a_pix_valid, a_pix_x, a_pix, a_done,
    input  b_ack, b_valid, b_pix, mem_select, mem_x, mem_y
  );
endinterface

// File: rtl/map_mem_arbiter.sv
// ---------------------------------------------------------------------------
// map_mem_arbiter
// Shares the map_mem sprite-pattern lookup between the display requester
// (port A, 16-pixel rows) and the game-logic requester (port B, single
// pixels). Fixed priority to A with a starvation limit for B; one address
// issued per cycle; returned pixels are routed back by a 2-stage tag pipe.
//   i_clock : system clock, rising edge
//   i_reset : synchronous active-high reset
//   bus     : map_mem_arbiter_if.slave (requester ports + map_mem bus)
// Parameter MAX_WAIT (1..15): A grants tolerated while B waits.
// ---------------------------------------------------------------------------
module map_mem_arbiter #(
  parameter int MAX_WAIT = 2
) (
  input  logic              i_clock,
  input  logic              i_reset,
  map_mem_arbiter_if.slave  bus
);

  localparam logic [3:0] STARVE_MAX = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BURST_A  = 2'd1,
    SINGLE_B = 2'd2
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;        // column currently on mem_x during a burst
  logic [3:0] r_starve, w_starve_nxt;
  logic       w_grant_a, w_grant_b;

  // next issue (loaded into the address register and tag stage 1 together)
  logic       w_issue, w_issue_b, w_issue_last;
  logic [5:0] w_issue_sel;
  logic [3:0] w_issue_x, w_issue_y;

  // address registers double as the latched request
  logic [5:0] r_mem_select;
  logic [3:0] r_mem_x, r_mem_y;

  // stage 1 aligns with the address, stage 2 with mem_out
  logic       r_s1_valid, r_s1_b, r_s1_last;
  logic [3:0] r_s1_x;
  logic       r_s2_valid, r_s2_b, r_s2_last;
  logic [3:0] r_s2_x;

  logic       r_a_pix_valid, r_a_done, r_b_valid;
  logic [3:0] r_a_pix_x;
  logic [1:0] r_a_pix, r_b_pix;

  logic       w_s2_a, w_s2_b;

  // grant decision, burst sequencing and next-issue selection
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_starve_nxt = r_starve;
    w_grant_a    = 1'b0;
    w_grant_b    = 1'b0;
    w_issue      = 1'b0;
    w_issue_b    = 1'b0;
    w_issue_last = 1'b0;
    w_issue_sel  = r_mem_select;
    w_issue_x    = 4'd0;
    w_issue_y    = r_mem_y;
    case (r_state)
      IDLE: begin
        if (bus.a_req && !(bus.b_req && (r_starve == STARVE_MAX))) begin
          w_grant_a   = 1'b1;
          w_issue     = 1'b1;
          w_issue_sel = bus.a_select;
          w_issue_y   = bus.a_y;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = BURST_A;
          // starve != MAX here whenever b_req is high, so +1 saturates naturally
          if (bus.b_req) begin
            w_starve_nxt = r_starve + 4'd1;
          end else begin
            w_starve_nxt = r_starve;
          end
        end else if (bus.b_req) begin
          w_grant_b    = 1'b1;
          w_issue      = 1'b1;
          w_issue_b    = 1'b1;
          w_issue_sel  = bus.b_select;
          w_issue_x    = bus.b_x;
          w_issue_y    = bus.b_y;
          w_starve_nxt = 4'd0;
          w_state_nxt  = SINGLE_B;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BURST_A: begin
        if (r_cnt == 4'd15) begin
          w_state_nxt = IDLE;
        end else begin
          w_issue      = 1'b1;
          w_issue_x    = r_cnt + 4'd1;
          w_issue_last = (r_cnt == 4'd14);
          w_cnt_nxt    = r_cnt + 4'd1;
        end
      end
      SINGLE_B: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_s2_a = r_s2_valid & ~r_s2_b;
  assign w_s2_b = r_s2_valid &  r_s2_b;

  // state, address, tag pipeline and output registers
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_cnt         <= 4'd0;
      r_starve      <= 4'd0;
      r_mem_select  <= 6'd0;
      r_mem_x       <= 4'd0;
      r_mem_y       <= 4'd0;
      r_s1_valid    <= 1'b0;
      r_s1_b        <= 1'b0;
      r_s1_last     <= 1'b0;
      r_s1_x        <= 4'd0;
      r_s2_valid    <= 1'b0;
      r_s2_b        <= 1'b0;
      r_s2_last     <= 1'b0;
      r_s2_x        <= 4'd0;
      r_a_pix_valid <= 1'b0;
      r_a_pix_x     <= 4'd0;
      r_a_pix       <= 2'd0;
      r_a_done      <= 1'b0;
      r_b_valid     <= 1'b0;
      r_b_pix       <= 2'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_starve <= w_starve_nxt;
      if (w_issue) begin
        r_mem_select <= w_issue_sel;
        r_mem_x      <= w_issue_x;
        r_mem_y      <= w_issue_y;
      end
      r_s1_valid    <= w_issue;
      r_s1_b        <= w_issue_b;
      r_s1_last     <= w_issue_last;
      r_s1_x        <= w_issue_x;
      r_s2_valid    <= r_s1_valid;
      r_s2_b        <= r_s1_b;
      r_s2_last     <= r_s1_last;
      r_s2_x        <= r_s1_x;
      r_a_pix_valid <= w_s2_a;
      r_a_pix_x     <= w_s2_a ? r_s2_x : 4'd0;
      r_a_pix       <= w_s2_a ? bus.mem_out : 2'd0;
      r_a_done      <= w_s2_a & r_s2_last;
      r_b_valid     <= w_s2_b;
      r_b_pix       <= w_s2_b ? bus.mem_out : 2'd0;
    end
  end

  // acks are suppressed while reset is held so nothing is lost into a reset
  assign bus.a_ack       = w_grant_a & ~i_reset;
  assign bus.b_ack       = w_grant_b & ~i_reset;
  assign bus.mem_select  = r_mem_select;
  assign bus.mem_x       = r_mem_x;
  assign bus.mem_y       = r_mem_y;
  assign bus.a_pix_valid = r_a_pix_valid;
  assign bus.a_pix_x     = r_a_pix_x;
  assign bus.a_pix       = r_a_pix;
  assign bus.a_done      = r_a_done;
  assign bus.b_valid     = r_b_valid;
  assign bus.b_pix       = r_b_pix;

endmodule
